// File: rtl/pipe_ctrl_pkg.sv
// Shared stall-code encoding for pipe_ctrl and every pipeline register it steers.
// NEXT advances a register, KEEP holds it, ZERO loads a bubble; 2'b11 is never driven.
package pipe_ctrl_pkg;

  typedef logic [1:0] stall_t;

  localparam stall_t STALL_NEXT = 2'b00;
  localparam stall_t STALL_KEEP = 2'b01;
  localparam stall_t STALL_ZERO = 2'b10;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard/busy inputs from the pipeline and the per-register stall codes back to it.
// master is the controller side, slave the pipeline side.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic   if_busy;
  logic   me_busy;
  logic   ex_busy;
  logic   id_load_use;
  logic   ex_branch_taken;
  logic   wb_exception_flag;
  logic   wb_mret;

  stall_t stall_pc;
  stall_t stall_if_id;
  stall_t stall_id_ex;
  stall_t stall_ex_me;
  stall_t stall_me_wb;
  logic   trap_redirect;

  modport master (
    input  if_busy, me_busy, ex_busy, id_load_use, ex_branch_taken,
           wb_exception_flag, wb_mret,
    output stall_pc, stall_if_id, stall_id_ex, stall_ex_me, stall_me_wb,
           trap_redirect
  );

  modport slave (
    output if_busy, me_busy, ex_busy, id_load_use, ex_branch_taken,
           wb_exception_flag, wb_mret,
    input  stall_pc, stall_if_id, stall_id_ex, stall_ex_me, stall_me_wb,
           trap_redirect
  );
endinterface

// File: rtl/pipe_ctrl_stall_counter.sv
// Free-running, wrapping count of cycles in which the PC was held.
module pipe_ctrl_stall_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller: resolves pipeline hazards into per-register stall codes
// and sequences trap/mret redirects after outstanding bus transactions drain.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipe_ctrl_if.master      bus,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    REDIR = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   drop_fetch, drop_nxt;
  stall_t pc_c, if_id_c, id_ex_c, ex_me_c, me_wb_c;
  logic   redirect_c;

  always_comb begin
    state_nxt  = state;
    drop_nxt   = drop_fetch;
    pc_c       = STALL_NEXT;
    if_id_c    = STALL_NEXT;
    id_ex_c    = STALL_NEXT;
    ex_me_c    = STALL_NEXT;
    me_wb_c    = STALL_NEXT;
    redirect_c = 1'b0;

    if (!rst) begin
      pc_c    = STALL_KEEP;
      if_id_c = STALL_ZERO;
      id_ex_c = STALL_ZERO;
      ex_me_c = STALL_ZERO;
      me_wb_c = STALL_ZERO;
    end else begin
      case (state)
        RUN: begin
          if (bus.wb_exception_flag || bus.wb_mret) begin
            pc_c      = STALL_KEEP;
            if_id_c   = STALL_ZERO;
            id_ex_c   = STALL_ZERO;
            ex_me_c   = STALL_ZERO;
            me_wb_c   = STALL_ZERO;
            state_nxt = DRAIN;
          end else if (bus.me_busy) begin
            pc_c    = STALL_KEEP;
            if_id_c = STALL_KEEP;
            id_ex_c = STALL_KEEP;
            ex_me_c = STALL_KEEP;
            me_wb_c = STALL_ZERO;
          end else if (bus.ex_busy) begin
            pc_c    = STALL_KEEP;
            if_id_c = STALL_KEEP;
            id_ex_c = STALL_KEEP;
            ex_me_c = STALL_ZERO;
          end else begin
            // Taken branch beats load-use: the ID instruction is on the wrong path.
            if (bus.ex_branch_taken) begin
              if_id_c  = STALL_ZERO;
              id_ex_c  = STALL_ZERO;
              drop_nxt = drop_fetch | bus.if_busy;
            end else if (bus.id_load_use) begin
              pc_c    = STALL_KEEP;
              if_id_c = STALL_KEEP;
              id_ex_c = STALL_ZERO;
            end else if (bus.if_busy) begin
              pc_c    = STALL_KEEP;
              if_id_c = STALL_ZERO;
            end
            // A fetch issued before a redirect lands stale; squash it unless if_id is held.
            if (drop_fetch && !bus.if_busy && if_id_c != STALL_KEEP) begin
              if_id_c = STALL_ZERO;
              if (!bus.ex_branch_taken) drop_nxt = 1'b0;
            end
          end
        end
        DRAIN: begin
          pc_c    = STALL_KEEP;
          if_id_c = STALL_ZERO;
          id_ex_c = STALL_ZERO;
          ex_me_c = STALL_ZERO;
          me_wb_c = STALL_ZERO;
          if (!bus.if_busy && !bus.me_busy) begin
            state_nxt = REDIR;
            drop_nxt  = 1'b0;
          end
        end
        REDIR: begin
          redirect_c = 1'b1;
          if_id_c    = STALL_ZERO;
          id_ex_c    = STALL_ZERO;
          ex_me_c    = STALL_ZERO;
          me_wb_c    = STALL_ZERO;
          state_nxt  = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RUN;
      drop_fetch <= 1'b0;
    end else begin
      state      <= state_nxt;
      drop_fetch <= drop_nxt;
    end
  end

  assign bus.stall_pc      = pc_c;
  assign bus.stall_if_id   = if_id_c;
  assign bus.stall_id_ex   = id_ex_c;
  assign bus.stall_ex_me   = ex_me_c;
  assign bus.stall_me_wb   = me_wb_c;
  assign bus.trap_redirect = redirect_c;

  pipe_ctrl_stall_counter #(
    .CNT_W (CNT_W)
  ) u_stall_counter (
    .clk (clk),
    .rst (rst),
    .en  (pc_c == STALL_KEEP),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios with literal expectations,
// then randomized hazards against a freeze-point model of the pipeline.
module tb_pipe_ctrl;

  localparam int CNT_W = 8;

  localparam logic [6:0] IFB = 7'b1000000;
  localparam logic [6:0] MEB = 7'b0100000;
  localparam logic [6:0] EXB = 7'b0010000;
  localparam logic [6:0] LDU = 7'b0001000;
  localparam logic [6:0] BRT = 7'b0000100;
  localparam logic [6:0] EXC = 7'b0000010;
  localparam logic [6:0] NIL = 7'b0000000;

  localparam logic [9:0] C_RUN   = 10'b00_00_00_00_00;
  localparam logic [9:0] C_MEB   = 10'b01_01_01_01_10;
  localparam logic [9:0] C_BR    = 10'b00_10_10_00_00;
  localparam logic [9:0] C_IFB   = 10'b01_10_00_00_00;
  localparam logic [9:0] C_DROP  = 10'b00_10_00_00_00;
  localparam logic [9:0] C_TRAP  = 10'b01_10_10_10_10;
  localparam logic [9:0] C_REDIR = 10'b00_10_10_10_10;

  logic             clk;
  logic             rst;
  logic [CNT_W-1:0] stall_cnt;
  int               checks;
  int               passes;

  pipe_ctrl_if bus ();

  pipe_ctrl #(
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .stall_cnt (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
  endtask

  function automatic logic [9:0] codes_now();
    return {bus.stall_pc, bus.stall_if_id, bus.stall_id_ex, bus.stall_ex_me, bus.stall_me_wb};
  endfunction

  // Registers 0..4 = pc, if_id, id_ex, ex_me, me_wb. Those before hold_n are held,
  // those in [lo,hi] take a bubble, the rest advance.
  function automatic logic [9:0] shape(input int hold_n, input int lo, input int hi);
    logic [9:0] r;
    logic [1:0] c;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      if (i < hold_n) c = 2'b01;
      else if (i >= lo && i <= hi) c = 2'b10;
      else c = 2'b00;
      r[9-2*i -: 2] = c;
    end
    return r;
  endfunction

  // Model state: trap drain in progress, redirect due, stale fetch pending, stall count.
  bit          m_drain, m_redir, m_stale;
  int unsigned m_cnt;

  always @(negedge clk) begin
    logic [9:0] exp_c;
    logic       exp_tr;
    bit         trap, busy, consumed;
    exp_tr   = 1'b0;
    consumed = 1'b0;
    trap     = bus.wb_exception_flag | bus.wb_mret;
    busy     = bus.me_busy | bus.ex_busy;
    if (!rst) begin
      m_cnt = 0;
      exp_c = shape(1, 1, 4);
    end else if (m_redir) begin
      exp_c  = shape(0, 1, 4);
      exp_tr = 1'b1;
    end else if (m_drain || trap) begin
      exp_c = shape(1, 1, 4);
    end else if (bus.me_busy) begin
      exp_c = shape(4, 4, 4);
    end else if (bus.ex_busy) begin
      exp_c = shape(3, 3, 3);
    end else if (bus.ex_branch_taken) begin
      exp_c = shape(0, 1, 2);
    end else if (bus.id_load_use) begin
      exp_c = shape(2, 2, 2);
    end else if (bus.if_busy) begin
      exp_c = shape(1, 1, 1);
    end else begin
      exp_c = shape(0, 9, 9);
    end
    if (rst && !m_redir && !m_drain && !trap && !busy && m_stale && !bus.if_busy
        && exp_c[7:6] != 2'b01) begin
      exp_c[7:6] = 2'b10;
      consumed   = 1'b1;
    end

    chk("codes", {22'd0, codes_now()}, {22'd0, exp_c});
    chk("trap_redirect", {31'd0, bus.trap_redirect}, {31'd0, exp_tr});
    chk("stall_cnt", {24'd0, stall_cnt}, m_cnt);

    if (!rst) begin
      m_drain = 0; m_redir = 0; m_stale = 0; m_cnt = 0;
    end else begin
      if (exp_c[9:8] == 2'b01) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      if (m_redir) m_redir = 0;
      else if (m_drain) begin
        if (!bus.if_busy && !bus.me_busy) begin
          m_drain = 0; m_redir = 1; m_stale = 0;
        end
      end else if (trap) m_drain = 1;
      else if (!busy) begin
        if (bus.ex_branch_taken) m_stale = m_stale | bus.if_busy;
        else if (consumed) m_stale = 0;
      end
    end
  end

  task automatic drive(input logic r, input logic [6:0] v);
    @(posedge clk);
    #1;
    rst = r;
    {bus.if_busy, bus.me_busy, bus.ex_busy, bus.id_load_use,
     bus.ex_branch_taken, bus.wb_exception_flag, bus.wb_mret} = v;
  endtask

  task automatic expect_cyc(input string nm, input logic [9:0] c, input logic tr);
    @(negedge clk);
    #1;
    chk({nm, "_codes"}, {22'd0, codes_now()}, {22'd0, c});
    chk({nm, "_trap"}, {31'd0, bus.trap_redirect}, {31'd0, tr});
  endtask

  initial begin
    checks = 0;
    passes = 0;
    m_drain = 0; m_redir = 0; m_stale = 0; m_cnt = 0;
    rst = 1'b0;
    {bus.if_busy, bus.me_busy, bus.ex_busy, bus.id_load_use,
     bus.ex_branch_taken, bus.wb_exception_flag, bus.wb_mret} = NIL;
    repeat (2) @(posedge clk);

    drive(1'b1, NIL); expect_cyc("reset_release", C_RUN, 1'b0);
    chk("reset_cnt", {24'd0, stall_cnt}, 32'd0);

    for (int i = 0; i < 3; i++) begin
      drive(1'b1, MEB); expect_cyc("me_busy", C_MEB, 1'b0);
    end
    drive(1'b1, NIL); expect_cyc("after_me", C_RUN, 1'b0);
    chk("me_busy_cnt", {24'd0, stall_cnt}, 32'd3);

    drive(1'b1, BRT | LDU); expect_cyc("br_over_lu", C_BR, 1'b0);
    drive(1'b1, NIL);       expect_cyc("br_no_drop", C_RUN, 1'b0);

    drive(1'b1, BRT | IFB); expect_cyc("br_ifbusy", C_BR, 1'b0);
    drive(1'b1, IFB);       expect_cyc("still_busy", C_IFB, 1'b0);
    drive(1'b1, NIL);       expect_cyc("stale_drop", C_DROP, 1'b0);
    drive(1'b1, NIL);       expect_cyc("post_drop", C_RUN, 1'b0);

    drive(1'b1, EXC | MEB); expect_cyc("trap_c0", C_TRAP, 1'b0);
    drive(1'b1, MEB);       expect_cyc("trap_c1", C_TRAP, 1'b0);
    drive(1'b1, NIL);       expect_cyc("trap_c2", C_TRAP, 1'b0);
    drive(1'b1, NIL);       expect_cyc("redirect", C_REDIR, 1'b1);
    drive(1'b1, NIL);       expect_cyc("post_redir", C_RUN, 1'b0);

    drive(1'b1, EXC);       expect_cyc("rst_trap", C_TRAP, 1'b0);
    drive(1'b1, MEB);       expect_cyc("rst_drain", C_TRAP, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst_codes", {22'd0, codes_now()}, {22'd0, C_TRAP});
    chk("async_rst_trap", {31'd0, bus.trap_redirect}, 32'd0);
    chk("async_rst_cnt", {24'd0, stall_cnt}, 32'd0);
    drive(1'b1, NIL);       expect_cyc("rst_run", C_RUN, 1'b0);
    chk("rst_run_cnt", {24'd0, stall_cnt}, 32'd0);

    for (int n = 0; n < 3000; n++) begin
      logic [6:0] v;
      v[6] = ($urandom_range(0, 99) < 30);
      v[5] = ($urandom_range(0, 99) < 15);
      v[4] = ($urandom_range(0, 99) < 15);
      v[3] = ($urandom_range(0, 99) < 15);
      v[2] = ($urandom_range(0, 99) < 20);
      v[1] = ($urandom_range(0, 99) < 3);
      v[0] = ($urandom_range(0, 99) < 3);
      drive(($urandom_range(0, 199) != 0), v);
    end
    drive(1'b1, NIL);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central stall/flush controller; sole producer of the 2-bit stall codes consumed by pc_reg, if_id, id_ex, ex_me and me_wb.
Resolves, in one cycle, the hazard and busy signals from every stage into per-register NEXT/KEEP/ZERO codes.
Owns the trap/mret flush sequence, which drains outstanding bus transactions, and the discard of fetches made stale by a redirect.

Parameters:
CNT_W, 32, width of stall-cycle performance counter

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
if_busy  in  1  instruction fetch outstanding, fetch data not valid this cycle
me_busy  in  1  data-memory access in ME not complete
ex_busy  in  1  multi-cycle mul/div in EX not complete
id_load_use  in  1  ID instruction needs result of load currently in EX
ex_branch_taken  in  1  EX resolves taken branch/jump (PC mispredict)
wb_exception_flag  in  1  exception committing in WB
wb_mret  in  1  mret committing in WB
stall_pc  out  2  pc_reg control
stall_if_id  out  2  if_id control
stall_id_ex  out  2  id_ex control
stall_ex_me  out  2  ex_me control
stall_me_wb  out  2  me_wb control
trap_redirect  out  1  PC selects mtvec/mepc this cycle
stall_cnt  out  CNT_W  cycles with stall_pc==KEEP

Behaviour:
- Codes (in defines.v): STALL_NEXT=2'b00, STALL_KEEP=2'b01, STALL_ZERO=2'b10; 2'b11 never driven.
- Stall outputs are combinational from state+inputs (same-cycle effect). State, drop_fetch and stall_cnt are flops.
- Reset (rst==0, async): state=RUN, drop_fetch=0, stall_cnt=0, trap_redirect=0.
  - While rst==0: stall_pc=KEEP, all other stall outputs=ZERO.
- FSM states: RUN, DRAIN, REDIR.
- RUN, priority high to low (first match wins):
  1. wb_exception_flag|wb_mret: pc KEEP; if_id, id_ex, ex_me, me_wb ZERO. Next state DRAIN.
  2. me_busy: pc, if_id, id_ex, ex_me KEEP; me_wb ZERO.
  3. ex_busy: pc, if_id, id_ex KEEP; ex_me ZERO; me_wb NEXT.
  4. ex_branch_taken: pc NEXT; if_id ZERO; id_ex ZERO; ex_me, me_wb NEXT.
     - Overrides id_load_use, because the ID instruction is wrong-path.
     - If if_busy is also set, set drop_fetch=1.
  5. id_load_use: pc, if_id KEEP; id_ex ZERO; ex_me, me_wb NEXT.
  6. if_busy: pc KEEP; if_id ZERO; rest NEXT.
  7. none: all NEXT.
- drop_fetch handling:
  - While drop_fetch==1 and if_busy==0, if_id is forced ZERO for that cycle and drop_fetch clears at the clock edge.
  - Rules 1-3 take precedence. If they hold if_id KEEP, the drop is deferred, with drop_fetch kept at 1.
  - A new taken branch while drop_fetch==1 leaves it at 1.
- DRAIN:
  - pc KEEP; all pipeline registers ZERO.
  - Exit to REDIR on the first cycle with if_busy==0 and me_busy==0; that cycle still drives DRAIN codes.
  - drop_fetch cleared on exit.
  - Branch, hazard and WB trap inputs are ignored.
- REDIR (exactly 1 cycle):
  - trap_redirect=1, pc NEXT, all pipeline registers ZERO; then RUN.
  - trap_redirect is 0 in all other states.
- stall_cnt:
  - +1 on every clock where rst==1 and stall_pc==KEEP; wraps modulo 2^CNT_W.
  - Not incremented in REDIR.
- Reset asserted mid-DRAIN or mid-REDIR aborts immediately to the reset values.

Decomposition:
- Stall encodings STALL_NEXT/KEEP/ZERO go in defines.v; they are shared with all pipeline registers.
- FSM state encodings are local parameters.
- One natural sub-module: stall_counter (CNT_W-bit wrapping counter with enable).
- Priority encoder stays inline.

Test Plan:
- Reset release, all inputs 0 -> first cycle all five stall outputs 2'b00, stall_cnt 0.
- me_busy=1 for 3 cycles -> pc/if_id/id_ex/ex_me=01, me_wb=10 each cycle; stall_cnt=3.
- ex_branch_taken=1 and id_load_use=1 same cycle -> pc=00, if_id=10, id_ex=10, ex_me=00, me_wb=00.
- ex_branch_taken with if_busy=1, then if_busy low 2 cycles later -> on that later cycle if_id=10; the following cycle all 00.
- wb_exception_flag=1 with me_busy=1 for 2 more cycles:
  - 3 cycles pc=01, others=10;
  - then one cycle trap_redirect=1, pc=00, others=10;
  - then RUN.
- rst low mid-DRAIN -> outputs immediately pc=01, others=10, trap_redirect 0; after release FSM in RUN, stall_cnt 0.
